// File: rtl/accumulator_sequencer_pkg.sv
// accumulator_sequencer_pkg: opcodes, FSM states, flag indices and arithmetic_unit select codes
package accumulator_sequencer_pkg;
   localparam logic [2:0] OP_LOAD   = 3'd0;
   localparam logic [2:0] OP_ADD    = 3'd1;
   localparam logic [2:0] OP_INC    = 3'd2;
   localparam logic [2:0] OP_SUB    = 3'd3;
   localparam logic [2:0] OP_DEC    = 3'd4;
   localparam logic [2:0] OP_REPADD = 3'd5;
   localparam logic [2:0] OP_CLR    = 3'd6;
   localparam logic [2:0] OP_NOP    = 3'd7;

   typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_REPEAT} state_e;

   localparam int FLG_N = 3;
   localparam int FLG_Z = 2;
   localparam int FLG_V = 1;
   localparam int FLG_C = 0;

   localparam logic [1:0] SEL_ADD = 2'b00;
   localparam logic [1:0] SEL_INC = 2'b01;
   localparam logic [1:0] SEL_SUB = 2'b10;
   localparam logic [1:0] SEL_DEC = 2'b11;

   function automatic logic [3:0] nz_only(input logic [7:0] v);
      logic [3:0] f;
      f = '0;
      f[FLG_N] = v[7];
      f[FLG_Z] = (v == 8'd0);
      return f;
   endfunction

   function automatic logic [1:0] alu_sel(input logic [2:0] op);
      return op == OP_INC ? SEL_INC : op == OP_SUB ? SEL_SUB : op == OP_DEC ? SEL_DEC : SEL_ADD;
   endfunction
endpackage

// File: rtl/arithmetic_unit.sv
// arithmetic_unit: combinational 8-bit add/inc/sub/dec with NZVC flags
module arithmetic_unit import accumulator_sequencer_pkg::*; (
   input  logic [7:0] a_i,
   input  logic [7:0] b_i,
   input  logic [1:0] sel_i,
   output logic [7:0] result_o,
   output logic [3:0] flags_o
);
   logic [7:0] y;
   logic       cin;
   logic [8:0] sum;
   // subtraction is A + ~B + 1, so carry-out set means no borrow
   always_comb begin
      cin      = (sel_i == SEL_SUB) || (sel_i == SEL_DEC);
      y        = sel_i == SEL_INC ? 8'h01 : sel_i == SEL_SUB ? ~b_i : sel_i == SEL_DEC ? 8'hFE : b_i;
      sum      = {1'b0, a_i} + {1'b0, y} + {8'd0, cin};
      result_o = sum[7:0];
      flags_o  = nz_only(sum[7:0]);
      flags_o[FLG_V] = (a_i[7] == y[7]) && (sum[7] != a_i[7]);
      flags_o[FLG_C] = sum[8];
   end
endmodule

// File: rtl/accumulator_sequencer.sv
// accumulator_sequencer: accumulator + NZVC register sequencing arithmetic_unit over a valid/ready command port
// Define ACCUMULATOR_STICKY_FLAGS_EN to OR-accumulate V/C across REPADD iterations.
module accumulator_sequencer import accumulator_sequencer_pkg::*; #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [2:0]       cmd_op,
   input  logic [WIDTH-1:0] cmd_operand,
   input  logic [CNT_W-1:0] cmd_count,
   output logic [WIDTH-1:0] acc_o,
   output logic [3:0]       nzvc_o,
   output logic             busy_o,
   output logic             done_o
);
   state_e           state_q, state_d;
   logic [WIDTH-1:0] acc_q, acc_d, operand_q, operand_d, alu_res;
   logic [3:0]       nzvc_q, nzvc_d, alu_flags, rep_flags;
   logic [2:0]       op_q, op_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             done_q, done_d, accept, arith;

   assign cmd_ready = (state_q == ST_IDLE) && !rst;
   assign accept    = cmd_valid && cmd_ready;
   assign arith     = op_q inside {OP_ADD, OP_INC, OP_SUB, OP_DEC};
   assign acc_o     = acc_q;
   assign nzvc_o    = nzvc_q;
   assign busy_o    = state_q != ST_IDLE;
   assign done_o    = done_q;

   arithmetic_unit u_alu (
      .a_i      (acc_q),
      .b_i      (operand_q),
      .sel_i    (alu_sel(op_q)),
      .result_o (alu_res),
      .flags_o  (alu_flags)
   );

`ifdef ACCUMULATOR_STICKY_FLAGS_EN
   logic [1:0] vc_q, vc_d;
   // V/C history is cleared on every accept so only the current REPADD contributes
   always_comb begin
      vc_d      = accept ? 2'b00 : state_q == ST_REPEAT ? vc_q | alu_flags[FLG_V:FLG_C] : vc_q;
      rep_flags = {alu_flags[FLG_N:FLG_Z], alu_flags[FLG_V:FLG_C] | vc_q};
   end
   always_ff @(posedge clk) vc_q <= rst ? 2'b00 : vc_d;
`else
   assign rep_flags = alu_flags;
`endif

   always_comb begin
      state_d   = state_q;
      acc_d     = acc_q;
      nzvc_d    = nzvc_q;
      op_d      = op_q;
      operand_d = operand_q;
      cnt_d     = cnt_q;
      done_d    = 1'b0;
      case (state_q)
         ST_IDLE: if (accept) begin
            op_d      = cmd_op;
            operand_d = cmd_operand;
            cnt_d     = cmd_count;
            state_d   = (cmd_op == OP_REPADD && cmd_count != '0) ? ST_REPEAT : ST_EXEC;
         end
         ST_EXEC: begin
            acc_d   = op_q == OP_LOAD ? operand_q : op_q == OP_CLR ? '0 : arith ? alu_res : acc_q;
            nzvc_d  = (op_q == OP_LOAD || op_q == OP_CLR) ? nz_only(acc_d) : arith ? alu_flags : nzvc_q;
            done_d  = 1'b1;
            state_d = ST_IDLE;
         end
         ST_REPEAT: begin
            acc_d  = alu_res;
            nzvc_d = rep_flags;
            cnt_d  = cnt_q - 1'b1;
            if (cnt_q == CNT_W'(1)) begin
               done_d  = 1'b1;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         acc_q     <= '0;
         nzvc_q    <= 4'b0100;
         op_q      <= OP_NOP;
         operand_q <= '0;
         cnt_q     <= '0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         acc_q     <= acc_d;
         nzvc_q    <= nzvc_d;
         op_q      <= op_d;
         operand_q <= operand_d;
         cnt_q     <= cnt_d;
         done_q    <= done_d;
      end
   end
endmodule

// File: tb/tb_accumulator_sequencer.sv
// tb_accumulator_sequencer: directed + randomized commands checked against an arithmetic reference model
module tb_accumulator_sequencer;
`ifdef ACCUMULATOR_STICKY_FLAGS_EN
   localparam bit STICKY = 1'b1;
`else
   localparam bit STICKY = 1'b0;
`endif
   logic       clk = 1'b0, rst = 1'b1, cmd_valid = 1'b0, cmd_ready;
   logic [2:0] cmd_op = 3'd7;
   logic [7:0] cmd_operand = 8'd0, acc_o;
   logic [3:0] cmd_count = 4'd0, nzvc_o;
   logic       busy_o, done_o;
   int         checks = 0, failures = 0, m_acc = 0, w;
   logic [3:0] m_f = 4'b0100;

   accumulator_sequencer dut (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cmd_operand(cmd_operand), .cmd_count(cmd_count),
      .acc_o(acc_o), .nzvc_o(nzvc_o), .busy_o(busy_o), .done_o(done_o)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic int sx(input int x);
      return x >= 128 ? x - 256 : x;
   endfunction

   task automatic m_add(input int y);
      int s, sv, r;
      s = m_acc + y;
      sv = sx(m_acc) + sx(y);
      r = s % 256;
      m_f = {r >= 128, r == 0, sv > 127 || sv < -128, s > 255};
      m_acc = r;
   endtask

   task automatic m_sub(input int y);
      int r, sv;
      r = (m_acc - y + 256) % 256;
      sv = sx(m_acc) - sx(y);
      m_f = {r >= 128, r == 0, sv > 127 || sv < -128, m_acc >= y};
      m_acc = r;
   endtask

   task automatic m_apply(input logic [2:0] op, input int b, input int c);
      logic [1:0] vc;
      vc = 2'b00;
      case (op)
         3'd0: begin m_acc = b; m_f = {b >= 128, b == 0, 2'b00}; end
         3'd1: m_add(b);
         3'd2: m_add(1);
         3'd3: m_sub(b);
         3'd4: m_sub(1);
         3'd5: begin
            for (int i = 0; i < c; i++) begin
               m_add(b);
               vc = vc | m_f[1:0];
            end
            if (STICKY && c > 0) m_f[1:0] = vc;
         end
         3'd6: begin m_acc = 0; m_f = 4'b0100; end
         default: ;
      endcase
   endtask

   function automatic int exp_busy(input logic [2:0] op, input logic [3:0] c);
      return (op == 3'd5 && c != 4'd0) ? int'(c) : 1;
   endfunction

   task automatic issue(input logic [2:0] op, input logic [7:0] b, input logic [3:0] c, output int waited);
      cmd_op = op;
      cmd_operand = b;
      cmd_count = c;
      cmd_valid = 1'b1;
      waited = 0;
      while (!cmd_ready && waited < 50) begin
         @(negedge clk);
         waited++;
      end
      check("accept_in_time", waited < 50, 1);
      @(posedge clk);
      m_apply(op, int'(b), int'(c));
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask

   task automatic finish_cmd(input string tag, input int eb);
      int n, g;
      n = 0;
      g = 0;
      while (!done_o && g < 50) begin
         if (busy_o) n++;
         @(negedge clk);
         g++;
      end
      check({tag, "_busy"}, n, eb);
      check({tag, "_acc"}, acc_o, m_acc[7:0]);
      check({tag, "_nzvc"}, nzvc_o, m_f);
      @(negedge clk);
      check({tag, "_done_pulse"}, done_o, 0);
   endtask

   task automatic run(input string tag, input logic [2:0] op, input logic [7:0] b, input logic [3:0] c);
      int wt;
      issue(op, b, c, wt);
      finish_cmd(tag, exp_busy(op, c));
   endtask

   initial begin
      @(negedge clk);
      check("rst_ready_low", cmd_ready, 0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("rst_acc", acc_o, 8'h00);
      check("rst_nzvc", nzvc_o, 4'b0100);
      check("rst_busy", busy_o, 0);
      check("rst_done", done_o, 0);
      check("rst_ready", cmd_ready, 1);
      @(negedge clk);

      run("load2", 3'd0, 8'h02, 4'd0);
      run("add3", 3'd1, 8'h03, 4'd0);
      check("add_const_acc", acc_o, 8'h05);
      check("add_const_nzvc", nzvc_o, 4'b0000);
      run("load2b", 3'd0, 8'h02, 4'd0);
      run("sub3", 3'd3, 8'h03, 4'd0);
      check("sub_const", {nzvc_o, acc_o}, {4'b1000, 8'hFF});
      run("clr", 3'd6, 8'h55, 4'd0);
      run("dec0", 3'd4, 8'h00, 4'd0);
      check("dec0_const", {nzvc_o, acc_o}, {4'b1000, 8'hFF});
      run("load7f", 3'd0, 8'h7F, 4'd0);
      run("inc7f", 3'd2, 8'h00, 4'd0);
      check("inc7f_const", {nzvc_o, acc_o}, {4'b1010, 8'h80});
      run("loadff", 3'd0, 8'hFF, 4'd0);
      run("incff", 3'd2, 8'h00, 4'd0);
      check("incff_const", {nzvc_o, acc_o}, {4'b0101, 8'h00});
      run("load10", 3'd0, 8'h10, 4'd0);
      run("repadd6", 3'd5, 8'h30, 4'd6);
      check("repadd6_const", {nzvc_o, acc_o}, {STICKY ? 4'b0011 : 4'b0000, 8'h30});
      run("repadd0", 3'd5, 8'h77, 4'd0);
      check("repadd0_const", {nzvc_o, acc_o}, {STICKY ? 4'b0011 : 4'b0000, 8'h30});
      run("nop", 3'd7, 8'h12, 4'd3);

      issue(3'd0, 8'h05, 4'd0, w);
      issue(3'd1, 8'h01, 4'd0, w);
      check("held_single_wait", w, 1);
      finish_cmd("held_add", 1);
      check("held_add_const", acc_o, 8'h06);
      issue(3'd5, 8'h03, 4'd3, w);
      issue(3'd7, 8'h00, 4'd0, w);
      check("held_rep_wait", w, 3);
      finish_cmd("held_nop", 1);

      issue(3'd5, 8'h01, 4'd8, w);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("midrst_ready_low", cmd_ready, 0);
      rst = 1'b0;
      m_acc = 0;
      m_f = 4'b0100;
      #1;
      check("midrst_acc", acc_o, 8'h00);
      check("midrst_nzvc", nzvc_o, 4'b0100);
      check("midrst_busy", busy_o, 0);
      check("midrst_ready", cmd_ready, 1);
      @(negedge clk);
      check("midrst_no_done", done_o, 0);

      for (int i = 0; i < 150; i++) begin
         logic [2:0] op, op2;
         logic [7:0] b;
         logic [3:0] c;
         op = 3'($urandom_range(7));
         b = 8'($urandom);
         c = 4'($urandom_range(7));
         issue(op, b, c, w);
         if ($urandom_range(3) == 0) begin
            op2 = 3'($urandom_range(7));
            issue(op2, 8'($urandom), 4'($urandom_range(5)), w);
            check("rnd_held_wait", w, exp_busy(op, c));
            finish_cmd("rnd_held", exp_busy(op2, cmd_count));
         end else begin
            finish_cmd("rnd", exp_busy(op, c));
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
